// File: rtl/wb_pkg.sv
// Shared types and helpers for the write buffer between the write-through cache and memory.
package wb_pkg;

  // FSM encoding
  typedef logic [1:0] wb_state_t;
  localparam wb_state_t StIdle    = 2'd0;
  localparam wb_state_t StRdIssue = 2'd1;
  localparam wb_state_t StRdWait  = 2'd2;
  localparam wb_state_t StResp    = 2'd3;

  // Default geometry
  localparam int unsigned WbAddrW = 32;
  localparam int unsigned WbDataW = 32;

  // One buffered write at the default geometry
  typedef struct packed {
    logic [WbAddrW-1:0] addr;
    logic [WbDataW-1:0] data;
  } wb_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Write-entry FIFO with a parallel youngest-match address search over valid entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = WbAddrW,
  parameter int unsigned DATA_W = WbDataW,
  localparam int unsigned PtrW  = ptr_width(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] search_addr,
  output logic              match,
  output logic [DATA_W-1:0] match_data,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful inside the valid window
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= '{addr: push_addr, data: push_data};
  end

  // Walk oldest to youngest so the last (youngest) match wins
  always_comb begin
    logic [PtrW-1:0] idx;
    idx        = '0;
    match      = 1'b0;
    match_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (mem_q[idx].addr == search_addr)) begin
        match      = 1'b1;
        match_data = mem_q[idx].data;
      end
    end
  end

  assign head_addr = mem_q[head_q].addr;
  assign head_data = mem_q[head_q].data;
  assign count     = count_q;

endmodule

// File: rtl/write_buffer.sv
// Write buffer: absorbs write-through traffic, drains it in the background and serves
// read misses by forwarding from buffered writes or by a downstream memory read.
module write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = WbAddrW,
  parameter int unsigned DATA_W = WbDataW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      up_address,
  input  logic                   up_read,
  input  logic                   up_write,
  input  logic [DATA_W-1:0]      up_write_data,
  output logic [DATA_W-1:0]      up_read_data,
  output logic                   up_busy,
  output logic [ADDR_W-1:0]      dn_address,
  output logic                   dn_read,
  output logic                   dn_write,
  output logic [DATA_W-1:0]      dn_write_data,
  input  logic [DATA_W-1:0]      dn_read_data,
  input  logic                   dn_busy,
  output logic [$clog2(DEPTH):0] wb_count,
  output logic                   wb_empty
);

  wb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              fifo_full, fifo_empty, fifo_match, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, match_data;
  logic              write_acc, read_acc;

  wb_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (write_acc),
    .push_addr  (up_address),
    .push_data  (up_write_data),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .search_addr(up_address),
    .match      (fifo_match),
    .match_data (match_data),
    .count      (wb_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // RESP is not busy so a new request can be taken in the response cycle
  assign up_busy   = fifo_full || (state_q == StRdIssue) || (state_q == StRdWait);
  assign write_acc = up_write && !up_busy;
  assign read_acc  = up_read && !up_write && !up_busy;

  // Drain whenever no downstream read is being driven
  assign dn_read  = (state_q == StRdIssue);
  assign dn_write = !dn_read && !fifo_empty;
  assign pop      = dn_write && !dn_busy;

  // Downstream port mux, zero when idle so the bus is quiet
  always_comb begin
    dn_address    = '0;
    dn_write_data = '0;
    if (dn_read) begin
      dn_address = rd_addr_q;
    end else if (dn_write) begin
      dn_address    = head_addr;
      dn_write_data = head_data;
    end
  end

  // Read FSM next state; the match uses pre-pop FIFO contents
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (read_acc) begin
          if (fifo_match) begin
            rdata_d = match_data;
            state_d = StResp;
          end else begin
            rd_addr_d = up_address;
            state_d   = StRdIssue;
          end
        end
      end
      StRdIssue: if (!dn_busy) state_d = StRdWait;
      StRdWait: begin
        if (!dn_busy) begin
          rdata_d = dn_read_data;
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign up_read_data = rdata_q;
  assign wb_empty     = fifo_empty;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: drain order, full stall, forwarding, read bypass,
// read/write collision and reset during a memory read.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] up_address, up_write_data, up_read_data;
  logic        up_read, up_write, up_busy;
  logic [31:0] dn_address, dn_write_data, dn_read_data;
  logic        dn_read, dn_write, dn_busy;
  logic [2:0]  wb_count;
  logic        wb_empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          rd_seen;
  int          overlap;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_address   (up_address),
    .up_read      (up_read),
    .up_write     (up_write),
    .up_write_data(up_write_data),
    .up_read_data (up_read_data),
    .up_busy      (up_busy),
    .dn_address   (dn_address),
    .dn_read      (dn_read),
    .dn_write     (dn_write),
    .dn_write_data(dn_write_data),
    .dn_read_data (dn_read_data),
    .dn_busy      (dn_busy),
    .wb_count     (wb_count),
    .wb_empty     (wb_empty)
  );

  // Memory-side monitor: completed writes and protocol observations
  always @(posedge clk) begin
    if (rst_n) begin
      if (dn_write && !dn_busy) begin
        log_addr.push_back(dn_address);
        log_data.push_back(dn_write_data);
      end
      if (dn_read) rd_seen++;
      if (dn_read && dn_write) overlap++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    up_write      = 1'b1;
    up_address    = a;
    up_write_data = d;
    tick();
    up_write      = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++; if (up_busy !== 1'b0) begin n_errors++; $display("FAIL reset_up_busy got %0b want 0", up_busy); end
    n_checks++; if (up_read_data !== 32'h0) begin n_errors++; $display("FAIL reset_up_read_data got %h want 0", up_read_data); end
    n_checks++; if (dn_read !== 1'b0 || dn_write !== 1'b0) begin n_errors++; $display("FAIL reset_dn_rw got %0b%0b want 00", dn_read, dn_write); end
    n_checks++; if (dn_address !== 32'h0 || dn_write_data !== 32'h0) begin n_errors++; $display("FAIL reset_dn_bus got %h/%h want 0/0", dn_address, dn_write_data); end
    n_checks++; if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin n_errors++; $display("FAIL reset_count got %0d/%0b want 0/1", wb_count, wb_empty); end
  endtask

  task automatic test_write_drain;
    dn_busy = 1'b0;
    log_addr.delete(); log_data.delete();
    up_write = 1'b1; up_address = 32'h10; up_write_data = 32'hA;
    tick();
    n_checks++; if (dn_write !== 1'b1 || dn_address !== 32'h10 || dn_write_data !== 32'hA) begin
      n_errors++; $display("FAIL drain_head0 got w=%0b a=%h d=%h want 1/10/a", dn_write, dn_address, dn_write_data); end
    up_address = 32'h11; up_write_data = 32'hB;
    tick();
    up_write = 1'b0;
    n_checks++; if (wb_count !== 3'd1 || dn_address !== 32'h11) begin
      n_errors++; $display("FAIL drain_pushpop got cnt=%0d a=%h want 1/11", wb_count, dn_address); end
    tick();
    tick();
    n_checks++; if (wb_empty !== 1'b1 || dn_write !== 1'b0) begin
      n_errors++; $display("FAIL drain_empty got e=%0b w=%0b want 1/0", wb_empty, dn_write); end
    n_checks++; if (log_addr.size() !== 2 || log_addr[0] !== 32'h10 || log_addr[1] !== 32'h11 ||
                    log_data[0] !== 32'hA || log_data[1] !== 32'hB) begin
      n_errors++; $display("FAIL drain_order got n=%0d want 10=a,11=b", log_addr.size()); end
  endtask

  task automatic test_full_stall;
    dn_busy = 1'b1;
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 4; i++) push_write(32'h50 + i, 32'h100 + i);
    n_checks++; if (wb_count !== 3'd4 || up_busy !== 1'b1) begin
      n_errors++; $display("FAIL full_count got cnt=%0d busy=%0b want 4/1", wb_count, up_busy); end
    up_write = 1'b1; up_address = 32'h54; up_write_data = 32'h104;
    tick();
    n_checks++; if (wb_count !== 3'd4) begin
      n_errors++; $display("FAIL full_hold got cnt=%0d want 4", wb_count); end
    dn_busy = 1'b0;
    tick();
    n_checks++; if (wb_count !== 3'd3 || up_busy !== 1'b0) begin
      n_errors++; $display("FAIL full_release got cnt=%0d busy=%0b want 3/0", wb_count, up_busy); end
    tick();
    up_write = 1'b0;
    n_checks++; if (wb_count !== 3'd3) begin
      n_errors++; $display("FAIL full_accept5 got cnt=%0d want 3", wb_count); end
    for (int i = 0; i < 20 && !wb_empty; i++) tick();
    n_checks++; if (wb_empty !== 1'b1) begin n_errors++; $display("FAIL full_drain_timeout got empty=%0b want 1", wb_empty); end
    begin
      logic ok;
      ok = (log_addr.size() == 5);
      for (int i = 0; i < 5 && ok; i++)
        if (log_addr[i] !== 32'h50 + i || log_data[i] !== 32'h100 + i) ok = 1'b0;
      n_checks++; if (!ok) begin n_errors++; $display("FAIL full_order got n=%0d want 5 in order 50..54", log_addr.size()); end
    end
  endtask

  task automatic test_forward;
    dn_busy = 1'b1;
    push_write(32'h20, 32'h1);
    push_write(32'h20, 32'h2);
    rd_seen = 0;
    up_read = 1'b1; up_address = 32'h20;
    tick();
    up_read = 1'b0;
    n_checks++; if (up_busy !== 1'b0 || up_read_data !== 32'h2) begin
      n_errors++; $display("FAIL fwd_data got busy=%0b data=%h want 0/2", up_busy, up_read_data); end
    tick();
    n_checks++; if (rd_seen !== 0 || wb_count !== 3'd2) begin
      n_errors++; $display("FAIL fwd_no_dnread got rd=%0d cnt=%0d want 0/2", rd_seen, wb_count); end
    dn_busy = 1'b0;
    for (int i = 0; i < 20 && !wb_empty; i++) tick();
    n_checks++; if (wb_empty !== 1'b1) begin n_errors++; $display("FAIL fwd_drain_timeout got empty=%0b want 1", wb_empty); end
  endtask

  task automatic test_read_bypass;
    dn_busy = 1'b1;
    overlap = 0;
    log_addr.delete(); log_data.delete();
    push_write(32'h30, 32'h5);
    up_read = 1'b1; up_address = 32'h40;
    tick();
    up_read = 1'b0;
    n_checks++; if (dn_read !== 1'b1 || dn_write !== 1'b0 || dn_address !== 32'h40 || up_busy !== 1'b1) begin
      n_errors++; $display("FAIL byp_issue got r=%0b w=%0b a=%h busy=%0b want 1/0/40/1",
                           dn_read, dn_write, dn_address, up_busy); end
    dn_busy = 1'b0;
    tick();
    dn_busy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (dn_read !== 1'b0 || up_busy !== 1'b1) begin
      n_errors++; $display("FAIL byp_wait got r=%0b busy=%0b want 0/1", dn_read, up_busy); end
    dn_busy = 1'b0; dn_read_data = 32'h77;
    tick();
    dn_read_data = 32'hDEAD;
    n_checks++; if (up_busy !== 1'b0 || up_read_data !== 32'h77) begin
      n_errors++; $display("FAIL byp_resp got busy=%0b data=%h want 0/77", up_busy, up_read_data); end
    for (int i = 0; i < 20 && !wb_empty; i++) tick();
    n_checks++; if (up_read_data !== 32'h77) begin
      n_errors++; $display("FAIL byp_hold got data=%h want 77", up_read_data); end
    n_checks++; if (overlap !== 0 || log_addr.size() !== 1 || log_addr[0] !== 32'h30 || log_data[0] !== 32'h5) begin
      n_errors++; $display("FAIL byp_drain got overlap=%0d n=%0d want 0/1 (30=5)", overlap, log_addr.size()); end
  endtask

  task automatic test_simultaneous;
    dn_busy = 1'b1;
    push_write(32'h60, 32'h7);
    dn_busy = 1'b0;
    up_write = 1'b1; up_read = 1'b1; up_address = 32'h60; up_write_data = 32'h8;
    tick();
    up_write = 1'b0; up_read = 1'b0;
    n_checks++; if (wb_count !== 3'd1) begin
      n_errors++; $display("FAIL simul_count got %0d want 1", wb_count); end
    n_checks++; if (up_read_data !== 32'h77 || dn_read !== 1'b0 || up_busy !== 1'b0) begin
      n_errors++; $display("FAIL simul_read_ignored got data=%h r=%0b busy=%0b want 77/0/0",
                           up_read_data, dn_read, up_busy); end
    n_checks++; if (dn_address !== 32'h60 || dn_write_data !== 32'h8) begin
      n_errors++; $display("FAIL simul_head got a=%h d=%h want 60/8", dn_address, dn_write_data); end
    for (int i = 0; i < 20 && !wb_empty; i++) tick();
    n_checks++; if (wb_empty !== 1'b1) begin n_errors++; $display("FAIL simul_drain_timeout got empty=%0b want 1", wb_empty); end
  endtask

  task automatic test_reset_mid_read;
    dn_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_write(32'h70 + i, 32'h200 + i);
    up_read = 1'b1; up_address = 32'h80;
    tick();
    up_read = 1'b0;
    dn_busy = 1'b0;
    tick();
    dn_busy = 1'b1;
    n_checks++; if (up_busy !== 1'b1 || wb_count !== 3'd3 || dn_read !== 1'b0) begin
      n_errors++; $display("FAIL rstrd_pre got busy=%0b cnt=%0d r=%0b want 1/3/0", up_busy, wb_count, dn_read); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (wb_count !== 3'd0 || wb_empty !== 1'b1 || up_busy !== 1'b0) begin
      n_errors++; $display("FAIL rstrd_count got cnt=%0d e=%0b busy=%0b want 0/1/0", wb_count, wb_empty, up_busy); end
    n_checks++; if (dn_read !== 1'b0 || dn_write !== 1'b0 || dn_address !== 32'h0 ||
                    dn_write_data !== 32'h0 || up_read_data !== 32'h0) begin
      n_errors++; $display("FAIL rstrd_outputs got r=%0b w=%0b a=%h d=%h rd=%h want all 0",
                           dn_read, dn_write, dn_address, dn_write_data, up_read_data); end
  endtask

  initial begin
    rst_n = 1'b0; up_address = '0; up_read = 1'b0; up_write = 1'b0; up_write_data = '0;
    dn_read_data = '0; dn_busy = 1'b0; rd_seen = 0; overlap = 0;
    #1;
    test_reset();
    test_write_drain();
    test_full_stall();
    test_forward();
    test_read_bypass();
    test_simultaneous();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
